scanline_buffer: RTL and testbench

- Downstream of the coordinate/input stage, after the per-pixel shape render pipeline.
- Captures rendered pixel colours for one screen row into a two-bank (ping-pong) line memory.
- Serves the completed row to the display scan-out logic.
- Pulses `resume` back upstream each time a completed row is handed to the display, which releases the upstream x/y sweep to render the next row.

---
 rtl/scanline_buffer.sv | 96 +++++++++
 tb/tb_scanline_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/scanline_buffer.sv
// Ping-pong row buffer between the render pipeline and display scan-out.
// One bank fills while the other is scanned out; line_done swaps them when the fill is complete.
module scanline_buffer #(
  parameter int                 WIDTH        = 1024,
  parameter int                 ADDR_W       = 10,
  parameter int                 DATA_W       = 12,
  parameter logic [DATA_W-1:0]  BLANK_COLOUR = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              program_in,
  input  logic              pix_valid,
  input  logic [11:0]       pix_x,
  input  logic [11:0]       pix_y,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              line_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [11:0]       rd_line_y,
  output logic              resume,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [11:0]     X_LIM  = 12'(WIDTH);
  localparam logic [11:0]     LAST_X = 12'(WIDTH - 1);
  localparam logic [ADDR_W:0] A_LIM  = (ADDR_W+1)'(WIDTH);

  state_t state, state_nxt;
  logic   wb;
  logic   wr_en, last, swap, under, ovf;
  logic [11:0]       tag [2];
  logic [DATA_W-1:0] mem [2][WIDTH];

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    last      = 1'b0;
    swap      = 1'b0;
    under     = 1'b0;
    ovf       = 1'b0;
    if (program_in) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL: begin
          wr_en = pix_valid && (pix_x < X_LIM);
          last  = wr_en && (pix_x == LAST_X);
          under = line_done;
          if (last) state_nxt = FULL;
        end
        FULL: begin
          // the full bank must not be touched until scan-out takes it
          ovf  = pix_valid;
          swap = line_done;
          if (line_done) state_nxt = FILL;
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wb][pix_x[ADDR_W-1:0]] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      wb        <= 1'b0;
      rd_valid  <= 1'b0;
      rd_line_y <= 12'd0;
      resume    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_data   <= BLANK_COLOUR;
    end else begin
      state  <= state_nxt;
      resume <= swap;
      if (ovf)   overflow  <= 1'b1;
      if (under) underflow <= 1'b1;
      if (last)  tag[wb]   <= pix_y;
      if (swap) begin
        wb        <= ~wb;
        rd_valid  <= 1'b1;
        rd_line_y <= tag[wb];
      end
      // uses pre-swap wb, so a read on the swap edge sees the old line
      rd_data <= (rd_valid && ({1'b0, rd_addr} < A_LIM)) ? mem[~wb][rd_addr] : BLANK_COLOUR;
    end
  end

endmodule

// File: tb/tb_scanline_buffer.sv
// Bench for scanline_buffer: directed row sequences then random traffic,
// every cycle compared against a two-line (filling / displayed) reference model.
module tb_scanline_buffer;
  logic        clk = 1'b0;
  logic        reset, program_in, pix_valid, line_done;
  logic [11:0] pix_x, pix_y, pix_data;
  logic [9:0]  rd_addr;
  logic [11:0] rd_data, rd_line_y;
  logic        rd_valid, resume, overflow, underflow;

  scanline_buffer dut (
    .clk(clk), .reset(reset), .program_in(program_in), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .line_done(line_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_line_y(rd_line_y),
    .resume(resume), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: the line being filled and the line on display, with known-pixel masks
  logic [11:0] wl [1024];
  logic [11:0] dl [1024];
  bit          wk [1024];
  bit          dk [1024];
  bit          m_full, m_dv, m_res, m_ovf, m_und;
  logic [11:0] m_wtag, m_dtag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit pv, input logic [11:0] px, input logic [11:0] py,
                     input logic [11:0] pd, input bit ld, input bit prog, input logic [9:0] ra);
    bit          rd_known, sw;
    logic [11:0] exp_rd, t;
    bit          tk;
    pix_valid = pv; pix_x = px; pix_y = py; pix_data = pd;
    line_done = ld; program_in = prog; rd_addr = ra;
    if (m_dv) begin rd_known = dk[ra]; exp_rd = dl[ra]; end
    else      begin rd_known = 1'b1;   exp_rd = 12'h000; end
    sw = 1'b0;
    if (prog) begin
      m_full = 1'b0;
    end else begin
      sw = ld && m_full;
      if (ld && !m_full) m_und = 1'b1;
      if (pv) begin
        if (m_full) m_ovf = 1'b1;
        else if (px < 12'd1024) begin
          wl[px[9:0]] = pd;
          wk[px[9:0]] = 1'b1;
          if (px == 12'd1023) begin m_full = 1'b1; m_wtag = py; end
        end
      end
      if (sw) begin
        for (int i = 0; i < 1024; i++) begin
          t = wl[i]; wl[i] = dl[i]; dl[i] = t;
          tk = wk[i]; wk[i] = dk[i]; dk[i] = tk;
        end
        m_dtag = m_wtag;
        m_dv   = 1'b1;
        m_full = 1'b0;
      end
    end
    m_res = sw;
    @(posedge clk); #1;
    chk("rd_valid",  32'(rd_valid),  32'(m_dv));
    chk("rd_line_y", 32'(rd_line_y), 32'(m_dtag));
    chk("resume",    32'(resume),    32'(m_res));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_und));
    if (rd_known) chk("rd_data", 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic idle(input logic [9:0] ra);
    cyc(1'b0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0, ra);
  endtask

  task automatic fill(input int x0, input int x1, input logic [11:0] y, input bit use_x, input logic [11:0] d);
    for (int x = x0; x <= x1; x++)
      cyc(1'b1, 12'(x), y, use_x ? 12'(x) : d, 1'b0, 1'b0, 10'(x));
  endtask

  initial begin
    int xc;
    bit pv, ld, prog;
    logic [11:0] px, py;
    for (int i = 0; i < 1024; i++) begin wk[i] = 1'b0; dk[i] = 1'b0; end
    reset = 1'b1; program_in = 1'b0; pix_valid = 1'b0; line_done = 1'b0;
    pix_x = '0; pix_y = '0; pix_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    m_full = 0; m_dv = 0; m_res = 0; m_ovf = 0; m_und = 0; m_wtag = 0; m_dtag = 0;
    chk("rst_rd_data",   32'(rd_data),   32'h0);
    chk("rst_rd_valid",  32'(rd_valid),  32'h0);
    chk("rst_rd_line_y", 32'(rd_line_y), 32'h0);
    chk("rst_resume",    32'(resume),    32'h0);
    chk("rst_overflow",  32'(overflow),  32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    reset = 1'b0;

    // row 0, data = x; nothing displayed yet
    fill(0, 1023, 12'd0, 1'b1, 12'h0);
    idle(10'd5); idle(10'd5);
    cyc(1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0, 10'd5);
    idle(10'd5); idle(10'd1023); idle(10'd1023);

    // row 1 solid, then a dropped write into the full bank
    fill(0, 1023, 12'd1, 1'b0, 12'hABC);
    cyc(1'b1, 12'd3, 12'd1, 12'h111, 1'b0, 1'b0, 10'd3);
    cyc(1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0, 10'd3);
    idle(10'd3); idle(10'd3);

    // partial row 2, early line_done re-displays row 1
    fill(0, 499, 12'd2, 1'b0, 12'h222);
    cyc(1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0, 10'd3);
    idle(10'd3); idle(10'd3);

    // program mode mid-fill discards the partial row
    fill(500, 600, 12'd2, 1'b0, 12'h222);
    repeat (3) cyc(1'b1, 12'd601, 12'd2, 12'h555, 1'b1, 1'b1, 10'd601);
    idle(10'd0);
    fill(0, 1023, 12'd7, 1'b0, 12'h0F0);
    cyc(1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0, 10'd0);
    idle(10'd0); idle(10'd0);

    // out-of-range column, then last pixel coincident with line_done
    cyc(1'b1, 12'd1024, 12'd9, 12'h777, 1'b0, 1'b0, 10'd0);
    for (int x = 0; x < 1023; x++)
      cyc(1'b1, 12'(x), 12'd9, 12'($urandom), 1'b0, 1'b0, 10'($urandom));
    cyc(1'b1, 12'd1023, 12'd9, 12'h999, 1'b1, 1'b0, 10'd1023);
    idle(10'd1023);
    cyc(1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0, 10'd1023);
    idle(10'd1023); idle(10'd1023); idle(10'd1);

    // random traffic
    xc = 0;
    py = 12'd20;
    for (int n = 0; n < 8000; n++) begin
      pv   = ($urandom % 4) != 0;
      ld   = ($urandom % 300) == 0;
      prog = ($urandom % 700) == 0;
      if (($urandom % 16) == 0) px = 12'($urandom % 1100);
      else begin
        px = 12'(xc);
        if (pv) xc = (xc + 1) % 1024;
        if (pv && px == 12'd1023) py = py + 12'd1;
      end
      cyc(pv, px, py, 12'($urandom), ld, prog, 10'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
